// File: rtl/pkg_processador.sv
// Shared definitions for the memory arbiter slice.
// Contents: default memory geometry, grant-counter width, FSM state
// encoding and a saturating-increment helper for the grant counters.
package pkg_processador;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;
  localparam int CONT_W     = 8;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONCEDE  = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  // Increment that sticks at the maximum value instead of wrapping.
  function automatic logic [CONT_W-1:0] sat_inc(input logic [CONT_W-1:0] v);
    logic [CONT_W-1:0] r;
    if (v == {CONT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CONT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbitro2.sv
// Two-way round-robin pick (purely combinational).
// Ports:
//   req  [1:0] in  : request vector, bit i = master i
//   prio       in  : master favoured when both request (0 or 1)
//   gnt  [1:0] out : one-hot winner, all zero when nobody requests
module rr_arbitro2
  import pkg_processador::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  // Single requester wins outright; contention goes to the favoured master.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/arbitro_mem.sv
// Arbiter sharing one single-port synchronous memory between master 0
// (CPU control) and master 1 (I/O loader).
// Ports:
//   clk, reset (async, active high)
//   req/we/addr/wdata 0|1  : request and its payload, held with req
//   gnt 0|1                : one-cycle grant pulse (request consumed)
//   rvalid 0|1, rdata      : one-cycle read-data pulse and the data
//   mem_addr/mem_wdata/mem_we, mem_rdata : memory side (rdata one cycle
//                            after the address)
//   ocupado                : high whenever a transaction is in flight
//   cont0/cont1            : saturating per-master grant counters
module arbitro_mem
  import pkg_processador::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ocupado,
  output logic [7:0]        cont0,
  output logic [7:0]        cont1
);

  estado_t     state;
  estado_t     state_next;
  logic        winner;   // master being served (0/1)
  logic        prio;     // master favoured on the next contention
  logic [1:0]  pick;
  logic        we_sel;

  rr_arbitro2 u_rr (
    .req  ({req1, req0}),
    .prio (prio),
    .gnt  (pick)
  );

  assign we_sel = winner ? we1 : we0;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= OCIOSO;
    end else begin
      state <= state_next;
    end
  end

  // Winner capture and round-robin pointer, both updated when leaving
  // OCIOSO for CONCEDE; the loser of this round is favoured next time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      winner <= 1'b0;
      prio   <= 1'b0;
    end else if ((state == OCIOSO) && (pick != 2'b00)) begin
      winner <= pick[1];
      prio   <= ~pick[1];
    end
  end

  // Grant counters, bumped once per grant cycle and saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cont0 <= 8'd0;
      cont1 <= 8'd0;
    end else if (state == CONCEDE) begin
      if (winner) begin
        cont1 <= sat_inc(cont1);
      end else begin
        cont0 <= sat_inc(cont0);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      OCIOSO: begin
        if (pick != 2'b00) begin
          state_next = CONCEDE;
        end else begin
          state_next = OCIOSO;
        end
      end
      CONCEDE: begin
        if (we_sel) begin
          state_next = OCIOSO;
        end else begin
          state_next = RESPOSTA;
        end
      end
      RESPOSTA: state_next = OCIOSO;
      default:  state_next = OCIOSO;
    endcase
  end

  // Outputs decoded from state; the memory port follows the winner's live
  // inputs only during CONCEDE and is parked at zero otherwise.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    rdata     = {DATA_W{1'b0}};
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    mem_we    = 1'b0;
    ocupado   = (state != OCIOSO);
    case (state)
      CONCEDE: begin
        gnt0      = ~winner;
        gnt1      = winner;
        mem_addr  = winner ? addr1 : addr0;
        mem_wdata = winner ? wdata1 : wdata0;
        mem_we    = we_sel;
      end
      RESPOSTA: begin
        rvalid0 = ~winner;
        rvalid1 = winner;
        rdata   = mem_rdata;
      end
      default: begin
        gnt0 = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_arbitro_mem.sv
// Directed self-checking bench for arbitro_mem with a behavioural
// synchronous single-port memory (128 x 32).
module tb_arbitro_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [6:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata = 32'd0;
  logic        ocupado;
  logic [7:0]  cont0, cont1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:127];
  logic        mem_init = 1'b0;

  arbitro_mem dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .ocupado   (ocupado),
    .cont0     (cont0),
    .cont1     (cont1)
  );

  always #5 clk = ~clk;

  // Memory model: first edge preloads contents, then synchronous write/read.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int k = 0; k < 128; k++) mem[k] <= 32'd0;
      mem[5]   <= 32'hDEADBEEF;
      mem_init <= 1'b1;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 7'd0; addr1 = 7'd0; wdata0 = 32'd0; wdata1 = 32'd0;
    @(negedge clk); @(negedge clk);

    // Reset state
    chk("rst_ocupado", ocupado, 32'd0);
    chk("rst_gnt0", gnt0, 32'd0);
    chk("rst_gnt1", gnt1, 32'd0);
    chk("rst_rvalid0", rvalid0, 32'd0);
    chk("rst_rvalid1", rvalid1, 32'd0);
    chk("rst_mem_we", mem_we, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_cont0", cont0, 32'd0);
    chk("rst_cont1", cont1, 32'd0);

    // Read from master 0 at 0x05
    reset = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 7'h05;
    @(negedge clk);
    chk("rd0_gnt0", gnt0, 32'd1);
    chk("rd0_gnt1", gnt1, 32'd0);
    chk("rd0_mem_addr", mem_addr, 32'h05);
    chk("rd0_mem_we", mem_we, 32'd0);
    chk("rd0_ocupado", ocupado, 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    chk("rd0_rvalid0", rvalid0, 32'd1);
    chk("rd0_rvalid1", rvalid1, 32'd0);
    chk("rd0_rdata", rdata, 32'hDEADBEEF);
    chk("rd0_gnt0_off", gnt0, 32'd0);
    chk("rd0_cont0", cont0, 32'd1);
    @(negedge clk);
    chk("rd0_idle", ocupado, 32'd0);
    chk("rd0_rvalid_off", rvalid0, 32'd0);
    chk("rd0_rdata_idle", rdata, 32'd0);
    chk("rd0_addr_idle", mem_addr, 32'd0);

    // Write from master 1 at 0x7F, then read it back
    req1 = 1'b1; we1 = 1'b1; addr1 = 7'h7F; wdata1 = 32'h12345678;
    @(negedge clk);
    chk("wr1_gnt1", gnt1, 32'd1);
    chk("wr1_gnt0", gnt0, 32'd0);
    chk("wr1_mem_we", mem_we, 32'd1);
    chk("wr1_mem_addr", mem_addr, 32'h7F);
    chk("wr1_mem_wdata", mem_wdata, 32'h12345678);
    req1 = 1'b0;
    @(negedge clk);
    chk("wr1_mem_we_off", mem_we, 32'd0);
    chk("wr1_wdata_idle", mem_wdata, 32'd0);
    chk("wr1_done_idle", ocupado, 32'd0);
    chk("wr1_cont1", cont1, 32'd1);
    we1 = 1'b0; req1 = 1'b1;
    @(negedge clk);
    chk("rd1_gnt1", gnt1, 32'd1);
    chk("rd1_mem_we", mem_we, 32'd0);
    req1 = 1'b0;
    @(negedge clk);
    chk("rd1_rvalid1", rvalid1, 32'd1);
    chk("rd1_rvalid0", rvalid0, 32'd0);
    chk("rd1_rdata", rdata, 32'h12345678);
    chk("rd1_cont1", cont1, 32'd2);
    @(negedge clk);
    chk("rd1_idle", ocupado, 32'd0);

    // req1 pulsed while master 0 is in CONCEDE: must never be granted
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h05;
    @(negedge clk);
    chk("pulse_gnt0", gnt0, 32'd1);
    req0 = 1'b0; req1 = 1'b1;
    @(negedge clk);
    chk("pulse_gnt1_a", gnt1, 32'd0);
    chk("pulse_rvalid0", rvalid0, 32'd1);
    req1 = 1'b0;
    @(negedge clk);
    chk("pulse_gnt1_b", gnt1, 32'd0);
    chk("pulse_idle", ocupado, 32'd0);
    @(negedge clk);
    chk("pulse_gnt1_c", gnt1, 32'd0);
    chk("pulse_cont1", cont1, 32'd2);
    chk("pulse_cont0", cont0, 32'd2);

    // Reset asserted during RESPOSTA
    req0 = 1'b1; addr0 = 7'h05;
    @(negedge clk);
    chk("abort_gnt0", gnt0, 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    chk("abort_in_resposta", rvalid0, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_rvalid0", rvalid0, 32'd0);
    chk("abort_ocupado", ocupado, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_cont0", cont0, 32'd0);
    chk("abort_cont1", cont1, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_post_rvalid0", rvalid0, 32'd0);
    chk("abort_post_ocupado", ocupado, 32'd0);
    @(negedge clk);
    chk("abort_post_rvalid0_b", rvalid0, 32'd0);

    // Both masters writing continuously: grants alternate 0,1,0,1
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'h10; wdata0 = 32'hA5A50001;
    req1 = 1'b1; we1 = 1'b1; addr1 = 7'h20; wdata1 = 32'h5A5A0002;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("rr_gnt0_%0d", i), gnt0, ((i % 4) == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr_gnt1_%0d", i), gnt1, ((i % 4) == 2) ? 32'd1 : 32'd0);
      chk($sformatf("rr_excl_%0d", i), gnt0 & gnt1, 32'd0);
      if ((i % 4) == 0) chk($sformatf("rr_addr_%0d", i), mem_addr, 32'h10);
      if ((i % 4) == 2) chk($sformatf("rr_addr_%0d", i), mem_addr, 32'h20);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("rr_cont0", cont0, 32'd2);
    chk("rr_cont1", cont1, 32'd2);
    chk("rr_mem10", mem[16], 32'hA5A50001);
    chk("rr_mem20", mem[32], 32'h5A5A0002);

    // 300 consecutive master-0 writes: counter saturates at 255
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'h33; wdata0 = 32'h0BADF00D;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i == 507) chk("sat_cont0_254", cont0, 32'd254);
      if (i == 509) chk("sat_cont0_255", cont0, 32'd255);
      if (i == 511) chk("sat_cont0_hold", cont0, 32'd255);
    end
    req0 = 1'b0;
    @(negedge clk);
    chk("sat_cont0_final", cont0, 32'd255);
    chk("sat_cont1_final", cont1, 32'd0);
    chk("sat_mem33", mem[51], 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
